fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the program counter and drives the combinational instruction memory address.
- Captures the returned word into the IF/ID pipeline register.
- Handles hazard-unit stalls, EX-stage redirects and IF/ID flushes. Decode consumes its outputs.

---
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address and fills the IF/ID register.
// Define FETCH_JAL_PREDICT_EN to redirect fetch early on JAL instructions.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int unsigned IMEM_WORDS = 101
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_instr,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_ifid_pc,
    output logic [31:0] o_ifid_pc4,
    output logic [31:0] o_ifid_instr,
    output logic        o_ifid_valid,
    output logic        o_ifid_oob,
    output logic        o_ifid_jal_pred
);

    localparam logic [31:0] IMEM_LIMIT_C = 32'(IMEM_WORDS);

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] jal_target_s;
    logic        in_range_s;
    logic        jal_hit_s;

    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_pc4_r;
    logic [31:0] ifid_instr_r;
    logic        ifid_valid_r;
    logic        ifid_oob_r;
    logic        ifid_jal_pred_r;

    assign pc_plus4_s = pc_r + 32'd4;
    assign in_range_s = ({2'b00, pc_r[31:2]} < IMEM_LIMIT_C);

`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [6:0] OPC_JAL_C = 7'b1101111;

    // J-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] jal_offset(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    assign jal_hit_s    = in_range_s && (i_imem_instr[6:0] == OPC_JAL_C);
    assign jal_target_s = pc_r + jal_offset(i_imem_instr);
`else
    assign jal_hit_s    = 1'b0;
    assign jal_target_s = pc_plus4_s;
`endif

    // Next-PC selection: redirect beats stall beats JAL prediction beats sequential
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (i_redirect_valid) begin
            pc_next_s = {i_redirect_pc[31:2], 2'b00};
        end else if (i_stall) begin
            pc_next_s = pc_r;
        end else if (jal_hit_s) begin
            pc_next_s = jal_target_s;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Program counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // IF/ID pipeline register: bubble on flush/redirect, hold on stall, else capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ifid_pc_r       <= 32'h0000_0000;
            ifid_pc4_r      <= 32'h0000_0004;
            ifid_instr_r    <= NOP_INSTR;
            ifid_valid_r    <= 1'b0;
            ifid_oob_r      <= 1'b0;
            ifid_jal_pred_r <= 1'b0;
        end else if (i_flush || i_redirect_valid) begin
            ifid_pc_r       <= pc_r;
            ifid_pc4_r      <= pc_plus4_s;
            ifid_instr_r    <= NOP_INSTR;
            ifid_valid_r    <= 1'b0;
            ifid_oob_r      <= 1'b0;
            ifid_jal_pred_r <= 1'b0;
        end else if (i_stall) begin
            ifid_pc_r       <= ifid_pc_r;
            ifid_pc4_r      <= ifid_pc4_r;
            ifid_instr_r    <= ifid_instr_r;
            ifid_valid_r    <= ifid_valid_r;
            ifid_oob_r      <= ifid_oob_r;
            ifid_jal_pred_r <= ifid_jal_pred_r;
        end else begin
            ifid_pc_r       <= pc_r;
            ifid_pc4_r      <= pc_plus4_s;
            ifid_instr_r    <= in_range_s ? i_imem_instr : NOP_INSTR;
            ifid_valid_r    <= in_range_s;
            ifid_oob_r      <= ~in_range_s;
            ifid_jal_pred_r <= jal_hit_s;
        end
    end

    assign o_imem_addr     = pc_r;
    assign o_ifid_pc       = ifid_pc_r;
    assign o_ifid_pc4      = ifid_pc4_r;
    assign o_ifid_instr    = ifid_instr_r;
    assign o_ifid_valid    = ifid_valid_r;
    assign o_ifid_oob      = ifid_oob_r;
    assign o_ifid_jal_pred = ifid_jal_pred_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences and a
// randomized run against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_JAL_PREDICT_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush, redir;
    logic [31:0] redir_pc;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
    logic        ifid_valid, ifid_oob, ifid_jal;

    logic [31:0] imem [0:127];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_addr(imem_addr), .i_imem_instr(imem_instr),
        .i_stall(stall), .i_flush(flush),
        .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
        .o_ifid_pc(ifid_pc), .o_ifid_pc4(ifid_pc4), .o_ifid_instr(ifid_instr),
        .o_ifid_valid(ifid_valid), .o_ifid_oob(ifid_oob), .o_ifid_jal_pred(ifid_jal)
    );

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        int unsigned idx;
        idx = addr / 4;
        if (idx < 128) return imem[idx];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instr = word_at(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rp);
        stall = s; flush = f; redir = r; redir_pc = rp;
    endtask

    // Behavioural model state
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_v, m_oob, m_jal;

    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic rv, input logic [31:0] rp);
        logic [31:0]        word, nxt;
        logic               inr, isjal;
        logic signed [20:0] imm;
        if (r) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'd4; m_instr = NOP;
            m_v = 1'b0; m_oob = 1'b0; m_jal = 1'b0;
            return;
        end
        inr   = (m_pc / 4) < 101;
        word  = word_at(m_pc);
        isjal = JAL_EN && inr && (word[6:0] == 7'h6F);
        imm   = $signed({word[31], word[19:12], word[20], word[30:21], 1'b0});
        if (rv)         nxt = rp & 32'hFFFF_FFFC;
        else if (s)     nxt = m_pc;
        else if (isjal) nxt = m_pc + 32'(int'(imm));
        else            nxt = m_pc + 32'd4;
        if (f || rv) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = NOP;
            m_v = 1'b0; m_oob = 1'b0; m_jal = 1'b0;
        end else if (!s) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
            m_instr = inr ? word : NOP;
            m_v = inr; m_oob = !inr; m_jal = isjal;
        end
        m_pc = nxt;
    endtask

    typedef struct {
        logic        s, f, r;
        logic [31:0] rpc, addr, pc, instr;
        logic        valid, oob;
    } vec_t;

    vec_t vt [10];

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = {18'h0, 7'(i), 7'b0010011};
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0010_0113;
        imem[2] = 32'h0020_81B3;
        imem[3] = 32'h0000_0013;

        //          s     f     r     rpc           addr          ifid pc       instr         v     oob
        vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0000, 32'h0050_0093, 1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 32'h0000_0004, 32'h0010_0113, 1'b1, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 32'h0000_0004, 32'h0010_0113, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 32'h0000_0004, 32'h0010_0113, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_000C, 32'h0000_0008, 32'h0020_81B3, 1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b1, 32'h42, 32'h0000_0040, 32'h0000_000C, NOP,         1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0044, 32'h0000_0040, 32'h0000_0813, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0044, 32'h0000_0044, NOP,         1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0048, 32'h0000_0044, NOP,         1'b0, 1'b0};
        vt[9] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_004C, 32'h0000_0048, 32'h0000_0913, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h4);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_flags", {29'h0, ifid_valid, ifid_oob, ifid_jal}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].s, vt[i].f, vt[i].r, vt[i].rpc);
            step();
            chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("vec%0d_pc", i), ifid_pc, vt[i].pc);
            chk($sformatf("vec%0d_pc4", i), ifid_pc4, vt[i].pc + 32'd4);
            chk($sformatf("vec%0d_instr", i), ifid_instr, vt[i].instr);
            chk($sformatf("vec%0d_flags", i), {29'h0, ifid_valid, ifid_oob, ifid_jal},
                {29'h0, vt[i].valid, vt[i].oob, 1'b0});
        end

        // Last valid word (index 100) then first out-of-range word
        drive(1'b0, 1'b0, 1'b1, 32'h0000_018C);
        step();
        chk("oob_redir_addr", imem_addr, 32'h0000_018C);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        chk("last_pc", ifid_pc, 32'h0000_0190);
        chk("last_instr", ifid_instr, 32'h0000_3213);
        chk("last_flags", {30'h0, ifid_valid, ifid_oob}, 32'h2);
        step();
        chk("oob_pc", ifid_pc, 32'h0000_0194);
        chk("oob_instr", ifid_instr, NOP);
        chk("oob_flags", {30'h0, ifid_valid, ifid_oob}, 32'h1);
        chk("oob_addr", imem_addr, 32'h0000_0198);

        // Low bits forced to zero, then wrap to 0
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step();
        chk("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        chk("wrap_oob", {31'h0, ifid_oob}, 32'h1);

        // Reset wins mid-stall with flush and redirect also asserted
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("prerst_addr", imem_addr, 32'h0000_0020);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        step();
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_pc", ifid_pc, 32'h0);
        chk("midrst_pc4", ifid_pc4, 32'h4);
        chk("midrst_instr", ifid_instr, NOP);
        chk("midrst_flags", {29'h0, ifid_valid, ifid_oob, ifid_jal}, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // JAL at word 2 (jal x0,+16)
        imem[2] = 32'h0100_006F;
        step();
        step();
        step();
        chk("jal_addr", imem_addr, JAL_EN ? 32'h0000_0018 : 32'h0000_000C);
        chk("jal_pc", ifid_pc, 32'h0000_0008);
        chk("jal_instr", ifid_instr, 32'h0100_006F);
        chk("jal_pred", {31'h0, ifid_jal}, {31'h0, JAL_EN});
        step();
        chk("jal_next_pc", ifid_pc, JAL_EN ? 32'h0000_0018 : 32'h0000_000C);
        chk("jal_next_pred", {31'h0, ifid_jal}, 32'h0);

        // Randomized run against the model
        rst = 1'b1;
        model_edge(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom % 60) == 0;
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 8) == 0;
            redir = ($urandom % 10) == 0;
            redir_pc = (($urandom % 4) == 0) ? $urandom : 32'($urandom_range(0, 32'h1B0));
            model_edge(rst, stall, flush, redir, redir_pc);
            step();
            chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_pc", ifid_pc, m_ipc);
            chk("rnd_pc4", ifid_pc4, m_ipc4);
            chk("rnd_instr", ifid_instr, m_instr);
            chk("rnd_flags", {29'h0, ifid_valid, ifid_oob, ifid_jal}, {29'h0, m_v, m_oob, m_jal});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
